core_in_desc_queue: RTL and testbench

Per-core input descriptor queue between the scheduler's descriptor distribution fabric and the RISC-V core wrapper's `in_desc` read port. It buffers up to `DEPTH` 64-bit descriptors arriving on a valid/ready stream and presents the oldest one, first-word-fall-through, on `in_desc`/`in_desc_valid`. The entry is popped when the core pulses `in_desc_taken`, which the core does by writing its read-descriptor strobe. The block also provides occupancy, a delivered-descriptor counter and a sticky underflow flag for the scheduler's status path.

---
 rtl/core_in_desc_queue_pkg.sv | 28 ++
 rtl/core_in_desc_queue_mem.sv | 24 ++
 rtl/core_in_desc_queue.sv | 101 ++++++++++
 tb/tb_core_in_desc_queue.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/core_in_desc_queue_pkg.sv
// Shared core interface definitions: IO addresses, descriptor field layout,
// default queue depth and the per-cycle queue operation encoding.
package core_in_desc_queue_pkg;

  localparam int unsigned CORE_IO_IN_DESC_LO_ADDR = 32'h0000_0100;
  localparam int unsigned CORE_IO_IN_DESC_HI_ADDR = 32'h0000_0104;
  localparam int unsigned CORE_IO_IN_DESC_TAKEN   = 32'h0000_0108;

  localparam int unsigned DESC_ADDR_LSB  = 0;
  localparam int unsigned DESC_ADDR_MSB  = 31;
  localparam int unsigned DESC_LEN_LSB   = 32;
  localparam int unsigned DESC_LEN_MSB   = 47;
  localparam int unsigned DESC_TAG_LSB   = 48;
  localparam int unsigned DESC_TAG_MSB   = 55;
  localparam int unsigned DESC_FLAGS_LSB = 56;
  localparam int unsigned DESC_FLAGS_MSB = 63;

  localparam int unsigned DEFAULT_DEPTH      = 8;
  localparam int unsigned DEFAULT_DESC_WIDTH = 64;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } q_op_e;

endpackage

// File: rtl/core_in_desc_queue_mem.sv
// Descriptor storage: register array, one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module desc_fifo_mem #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DESC_WIDTH = 64,
  parameter int unsigned PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [PTR_W-1:0]      waddr_i,
  input  logic [DESC_WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0]      raddr_i,
  output logic [DESC_WIDTH-1:0] rdata_o
);

  logic [DESC_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/core_in_desc_queue.sv
// Per-core input descriptor queue: FWFT circular buffer between the scheduler
// descriptor stream and the core's in_desc read port, with status counters.
module core_in_desc_queue
  import core_in_desc_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned DESC_WIDTH = DEFAULT_DESC_WIDTH,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned OCC_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DESC_WIDTH-1:0] s_desc,
  input  logic                  s_desc_valid,
  output logic                  s_desc_ready,
  input  logic                  flush,
  output logic [DESC_WIDTH-1:0] in_desc,
  output logic                  in_desc_valid,
  input  logic                  in_desc_taken,
  output logic [OCC_WIDTH-1:0]  occupancy,
  output logic [CNT_WIDTH-1:0]  taken_count,
  output logic                  underflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCC_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] taken_q, taken_d;
  logic                 uflow_q, uflow_d;
  logic                 full, empty, push, pop;
  q_op_e                op;

  assign full  = (count_q == OCC_WIDTH'(DEPTH));
  assign empty = (count_q == '0);
  // No write-through when full: a same-cycle pop does not free a slot for the push.
  assign push  = s_desc_valid && !full && !flush;
  assign pop   = in_desc_taken && !empty && !flush;
  assign op    = q_op_e'({push, pop});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    taken_d  = taken_q;
    uflow_d  = uflow_q || (in_desc_taken && empty);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        taken_d  = taken_q + CNT_WIDTH'(1);
      end
      unique case (op)
        OP_PUSH: count_d = count_q + OCC_WIDTH'(1);
        OP_POP:  count_d = count_q - OCC_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      taken_q  <= '0;
      uflow_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      taken_q  <= taken_d;
      uflow_q  <= uflow_d;
    end
  end

  desc_fifo_mem #(
    .DEPTH      (DEPTH),
    .DESC_WIDTH (DESC_WIDTH),
    .PTR_W      (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_desc),
    .raddr_i (rd_ptr_q),
    .rdata_o (in_desc)
  );

  assign s_desc_ready  = !full;
  assign in_desc_valid = !empty;
  assign occupancy     = count_q;
  assign taken_count   = taken_q;
  assign underflow_err = uflow_q;

endmodule

// File: tb/tb_core_in_desc_queue.sv
// Scoreboard bench for core_in_desc_queue: accepted descriptors are queued
// on push and compared against the FWFT head every cycle.
module tb_core_in_desc_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [63:0]       s_desc = '0;
  logic              s_desc_valid = 1'b0;
  logic              s_desc_ready;
  logic              flush = 1'b0;
  logic [63:0]       in_desc;
  logic              in_desc_valid;
  logic              in_desc_taken = 1'b0;
  logic [OCC_W-1:0]  occupancy;
  logic [31:0]       taken_count;
  logic              underflow_err;

  core_in_desc_queue #(
    .DEPTH      (DEPTH),
    .DESC_WIDTH (64),
    .CNT_WIDTH  (32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_desc        (s_desc),
    .s_desc_valid  (s_desc_valid),
    .s_desc_ready  (s_desc_ready),
    .flush         (flush),
    .in_desc       (in_desc),
    .in_desc_valid (in_desc_valid),
    .in_desc_taken (in_desc_taken),
    .occupancy     (occupancy),
    .taken_count   (taken_count),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  logic [63:0] sb[$];
  int unsigned m_taken = 0;
  logic        m_uflow = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("ready", 64'(s_desc_ready), 64'(sb.size() < DEPTH));
    chk("valid", 64'(in_desc_valid), 64'(sb.size() != 0));
    chk("occupancy", 64'(occupancy), 64'(sb.size()));
    chk("taken_count", 64'(taken_count), 64'(m_taken));
    chk("underflow", 64'(underflow_err), 64'(m_uflow));
    if (sb.size() != 0) chk("head", in_desc, sb[0]);
  endtask

  // Called just after a posedge; drives one cycle, checks at negedge, updates model at posedge.
  task automatic cyc(input logic v, input logic [63:0] d, input logic tk, input logic fl);
    bit was_empty, was_full;
    s_desc_valid  = v;
    s_desc        = d;
    in_desc_taken = tk;
    flush         = fl;
    @(negedge clk);
    check_outputs();
    was_empty = (sb.size() == 0);
    was_full  = (sb.size() == DEPTH);
    @(posedge clk);
    if (tk && was_empty) m_uflow = 1'b1;
    if (fl) sb.delete();
    else begin
      if (tk && !was_empty) begin
        void'(sb.pop_front());
        m_taken++;
      end
      if (v && !was_full) sb.push_back(d);
    end
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic idle(); cyc(1'b0, '0, 1'b0, 1'b0); endtask
  task automatic push(input logic [63:0] d); cyc(1'b1, d, 1'b0, 1'b0); endtask
  task automatic pop(); cyc(1'b0, '0, 1'b1, 1'b0); endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic push then FWFT visibility
    idle();
    push(64'h1111_2222_3333_4444);
    idle();
    pop();
    idle();

    // Fill to full, refused 9th push, pop while full still refuses the push
    for (int i = 0; i < 8; i++) push(rnd64());
    cyc(1'b1, rnd64(), 1'b0, 1'b0);
    cyc(1'b1, rnd64(), 1'b1, 1'b0);
    push(rnd64());
    for (int i = 0; i < 3; i++) pop();
    for (int i = 0; i < 3; i++) push(rnd64());
    while (sb.size() > 3) pop();

    // Sustained push+pop at occupancy 3
    for (int i = 0; i < 20; i++) cyc(1'b1, rnd64(), 1'b1, 1'b0);
    while (sb.size() != 0) pop();

    // Underflow: sticky, counters untouched
    pop();
    idle();
    pop();
    idle();

    // Flush with concurrent push and pop at occupancy 5
    for (int i = 0; i < 5; i++) push(rnd64());
    cyc(1'b1, rnd64(), 1'b1, 1'b1);
    idle();
    push(rnd64());
    pop();

    // Asynchronous reset at occupancy 4, away from any clock edge
    for (int i = 0; i < 4; i++) push(rnd64());
    idle();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_taken = 0;
    m_uflow = 1'b0;
    chk("rst_ready", 64'(s_desc_ready), 64'd1);
    chk("rst_valid", 64'(in_desc_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_taken_count", 64'(taken_count), 64'd0);
    chk("rst_underflow", 64'(underflow_err), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(64'hDEAD_BEEF_CAFE_F00D);
    idle();
    pop();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected completion by 200000");
    $fatal(1);
  end

endmodule
